cruise_panel: RTL and testbench
===============================

CRUISE_PANEL -- requirements
Module: cruise_panel

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles needed before a debounced level changes (range 1..255).
REQ-002 Parameter RPT_DELAY, default 16: held cycles after the first accel/coast pulse before auto-repeat starts (range 2..255).
REQ-003 Parameter RPT_RATE, default 4: cycles between auto-repeat pulses (range 1..255).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_set, btn_accel, btn_coast, btn_cancel, btn_resume  input  1 each  raw, asynchronous, bouncing driver buttons; high = pressed.
REQ-007 pedal_brake, pedal_gas  input  1 each  raw, asynchronous pedal switches; high = pressed.
REQ-008 cruisectrl  input  1  cruise-engaged status fed back from the cruise controller.
REQ-009 set, accel, coast, cancel, resume  output  1 each  registered single-cycle command pulses to the cruise controller.
REQ-010 brake, throttle  output  1 each  registered debounced pedal levels.
REQ-011 conflict  output  1  registered level; high while accel and coast are both debounced-pressed.

Function
REQ-012 Each raw input shall pass through a two-flop synchronizer before any other use.
REQ-013 Each input shall have its own debounce counter, 8 bits wide: it increments while the synchronized value differs from the debounced level, clears when they match, and on reaching DEB_CYCLES toggles the debounced level and clears.
REQ-014 Latency from a clean raw edge to the matching output change shall be exactly DEB_CYCLES+3 rising edges: 2 for sync, DEB_CYCLES for debounce, 1 for the output register.
REQ-015 brake and throttle shall follow the debounced pedal levels with no edge detection.
REQ-016 A button request shall be generated only on a debounced rising edge, or by auto-repeat under REQ-020.
REQ-017 While debounced brake is high, all button requests shall be discarded, including auto-repeat, and the repeat counters held at 0.
REQ-018 Per-cycle priority shall be cancel > resume > set > accel > coast; at most one pulse output is high in any cycle, and losing requests are dropped, not queued.
REQ-019 Gating: resume and set are emitted only when cruisectrl=0; accel and coast only when cruisectrl=1; a gated request is dropped.
REQ-020 Auto-repeat: each of accel and coast has a repeat FSM with states IDLE, DELAY and REPEAT.
  - IDLE->DELAY on the debounced rising edge.
  - DELAY->REPEAT after RPT_DELAY cycles held, issuing a request.
  - In REPEAT, a request every RPT_RATE cycles.
  - Any state->IDLE on debounced release.
REQ-021 Conflict: while accel and coast are both debounced high, conflict=1, both repeat FSMs are forced to IDLE, and no accel or coast requests are issued; normal operation resumes only after a fresh rising edge.
REQ-022 cancel, set and resume shall never auto-repeat; holding one yields exactly one request.
REQ-023 Repeat counters shall be 8 bits and shall saturate, never wrap.

Reset
REQ-024 While reset is high, all outputs shall be 0 and all synchronizer flops, debounced levels, debounce counters, repeat counters and repeat FSMs shall be 0/IDLE.
REQ-025 Reset asserted mid-press shall abort any pending or repeating request; after release, an input already held high produces its rising-edge pulse DEB_CYCLES+3 edges later, as if newly pressed.

Verification
REQ-026 All scenarios use default parameters.
  - Scenario 1: btn_set held high with cruisectrl=0 -> set=1 for exactly one cycle, 7 edges after the raw rise; no further set pulses.
  - Scenario 2: btn_cancel glitching high for 3 cycles and low for 1, repeatedly -> no cancel pulse and no debounced change.
  - Scenario 3: btn_accel held 40 cycles with cruisectrl=1 -> accel pulses at edges 7, 23, 27, 31, 35, 39 relative to the raw rise.
  - Scenario 4: btn_cancel and btn_resume rise in the same cycle with cruisectrl=0 -> only cancel pulses; resume is never emitted.
  - Scenario 5: pedal_brake held high, then btn_set pressed -> brake=1 and no set pulse; releasing the brake while set is still held gives no set pulse.
  - Scenario 6: accel and coast both held -> conflict=1 and no accel/coast pulses; asserting reset mid-hold clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/cruise_panel.sv
// Driver cruise-control button panel: synchronizes and debounces buttons and pedals,
// then issues prioritized, gated single-cycle commands with accel/coast auto-repeat.
module cruise_panel #(
  parameter int DEB_CYCLES = 4,
  parameter int RPT_DELAY  = 16,
  parameter int RPT_RATE   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_accel,
  input  logic btn_coast,
  input  logic btn_cancel,
  input  logic btn_resume,
  input  logic pedal_brake,
  input  logic pedal_gas,
  input  logic cruisectrl,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic brake,
  output logic throttle,
  output logic conflict
);

  localparam int N = 7;
  localparam logic [7:0] DEB_M1 = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] RD_M1  = 8'(RPT_DELAY - 1);
  localparam logic [7:0] RR_M1  = 8'(RPT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_t;

  logic [N-1:0] raw;
  logic [N-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N-1:0] deb_q, deb_d, prev_q, prev_d, rise;
  logic [7:0]   cnt_q [N];
  logic [7:0]   cnt_d [N];
  rpt_t         st_q [2];
  rpt_t         st_d [2];
  logic [7:0]   rcnt_q [2];
  logic [7:0]   rcnt_d [2];
  logic [1:0]   rpt_req;
  logic [4:0]   pulse_q, pulse_d;
  logic [2:0]   lvl_q, lvl_d;
  logic         brk, conf;
  logic         r_set, r_accel, r_coast, r_cancel, r_resume;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // bit order: set, accel, coast, cancel, resume, brake, gas
  assign raw = {pedal_gas, pedal_brake, btn_resume, btn_cancel, btn_coast, btn_accel, btn_set};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = deb_q;
    for (int i = 0; i < N; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] >= DEB_M1) deb_d[i] = ~deb_q[i];
        else                    cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  assign rise = deb_q & ~prev_q;
  assign brk  = deb_q[5];
  assign conf = deb_q[1] & deb_q[2];

  // Repeat FSMs: k=0 accel, k=1 coast. Brake, conflict or release park them in IDLE,
  // so only a fresh debounced rising edge can restart repeating.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k]    = st_q[k];
      rcnt_d[k]  = rcnt_q[k];
      rpt_req[k] = 1'b0;
      if (brk || conf || !deb_q[k+1]) begin
        st_d[k]   = IDLE;
        rcnt_d[k] = '0;
      end else begin
        case (st_q[k])
          IDLE: begin
            if (rise[k+1]) begin
              st_d[k]   = DELAY;
              rcnt_d[k] = '0;
            end
          end
          DELAY: begin
            if (rcnt_q[k] >= RD_M1) begin
              rpt_req[k] = 1'b1;
              st_d[k]    = REPEAT;
              rcnt_d[k]  = '0;
            end else begin
              rcnt_d[k] = sat_inc(rcnt_q[k]);
            end
          end
          REPEAT: begin
            if (rcnt_q[k] >= RR_M1) begin
              rpt_req[k] = 1'b1;
              rcnt_d[k]  = '0;
            end else begin
              rcnt_d[k] = sat_inc(rcnt_q[k]);
            end
          end
          default: begin
            st_d[k]   = IDLE;
            rcnt_d[k] = '0;
          end
        endcase
      end
    end
  end

  // Gating drops a request before arbitration; losers of the priority chain are dropped.
  always_comb begin
    r_cancel = rise[3] & ~brk;
    r_resume = rise[4] & ~brk & ~cruisectrl;
    r_set    = rise[0] & ~brk & ~cruisectrl;
    r_accel  = (rise[1] | rpt_req[0]) & ~brk & ~conf & cruisectrl;
    r_coast  = (rise[2] | rpt_req[1]) & ~brk & ~conf & cruisectrl;
    pulse_d  = '0;
    if      (r_cancel) pulse_d[3] = 1'b1;
    else if (r_resume) pulse_d[4] = 1'b1;
    else if (r_set)    pulse_d[0] = 1'b1;
    else if (r_accel)  pulse_d[1] = 1'b1;
    else if (r_coast)  pulse_d[2] = 1'b1;
    lvl_d = {conf, deb_q[6], deb_q[5]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      lvl_q   <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      for (int k = 0; k < 2; k++) begin
        st_q[k]   <= IDLE;
        rcnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      lvl_q   <= lvl_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      for (int k = 0; k < 2; k++) begin
        st_q[k]   <= st_d[k];
        rcnt_q[k] <= rcnt_d[k];
      end
    end
  end

  assign set      = pulse_q[0];
  assign accel    = pulse_q[1];
  assign coast    = pulse_q[2];
  assign cancel   = pulse_q[3];
  assign resume   = pulse_q[4];
  assign brake    = lvl_q[0];
  assign throttle = lvl_q[1];
  assign conflict = lvl_q[2];

endmodule

// File: tb/tb_cruise_panel.sv
// Scoreboard bench for cruise_panel: per-cycle expected outputs are queued as stimulus
// is applied and compared one cycle-slot later against the registered outputs.
module tb_cruise_panel;

  logic clk, reset;
  logic btn_set, btn_accel, btn_coast, btn_cancel, btn_resume, pedal_brake, pedal_gas;
  logic cruisectrl;
  logic set, accel, coast, cancel, resume, brake, throttle, conflict;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  cruise_panel dut (
    .clk(clk), .reset(reset),
    .btn_set(btn_set), .btn_accel(btn_accel), .btn_coast(btn_coast),
    .btn_cancel(btn_cancel), .btn_resume(btn_resume),
    .pedal_brake(pedal_brake), .pedal_gas(pedal_gas), .cruisectrl(cruisectrl),
    .set(set), .accel(accel), .coast(coast), .cancel(cancel), .resume(resume),
    .brake(brake), .throttle(throttle), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output vector: {conflict, throttle, brake, resume, cancel, coast, accel, set}
  function automatic logic [7:0] outs();
    return {conflict, throttle, brake, resume, cancel, coast, accel, set};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] b, input logic cc);
    {pedal_gas, pedal_brake, btn_resume, btn_cancel, btn_coast, btn_accel, btn_set} = b;
    cruisectrl = cc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(7'd0, 1'b0);
    #1;
    check_eq("reset_async", outs(), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_held", outs(), 8'h00);
    reset = 1'b0;
  endtask

  // Stimulus for cycle c (applied before rising edge c) of scenario id.
  task automatic stim(input int id, input int c, output logic [6:0] b, output logic cc);
    b  = '0;
    cc = 1'b0;
    case (id)
      1: b[0] = 1'b1;
      2: b[3] = (((c - 1) % 4) < 3);
      3: begin b[1] = 1'b1; cc = 1'b1; end
      4: begin b[3] = 1'b1; b[4] = 1'b1; end
      5: begin b[5] = (c < 20); b[6] = (c <= 10); b[0] = (c >= 10); end
      6: begin b[1] = 1'b1; b[2] = 1'b1; cc = 1'b1; end
      7: begin b[1] = 1'b1; b[2] = (c >= 10 && c <= 20); cc = 1'b1; end
      8: begin b[3] = 1'b1; b[1] = 1'b1; cc = 1'b1; end
      default: ;
    endcase
  endtask

  // Expected outputs right after rising edge c: raw edge to output takes 7 edges.
  function automatic logic [7:0] expect_at(input int id, input int c);
    logic [7:0] e;
    e = '0;
    case (id)
      1: e[0] = (c == 7);
      3: e[1] = (c == 7 || c == 23 || c == 27 || c == 31 || c == 35 || c == 39);
      4: e[3] = (c == 7);
      5: begin e[5] = (c >= 7 && c <= 25); e[6] = (c >= 7 && c <= 16); end
      6: e[7] = (c >= 7);
      7: begin e[1] = (c == 7); e[7] = (c >= 16 && c <= 26); end
      8: begin e[3] = (c == 7); e[1] = (c == 23); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_scn(input int id, input int ncyc);
    logic [6:0] b;
    logic cc;
    logic [7:0] e;
    do_reset();
    for (int c = 1; c <= ncyc; c++) begin
      stim(id, c, b, cc);
      drive(b, cc);
      exp_q.push_back(expect_at(id, c));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("scn%0d_c%0d", id, c), outs(), e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(7'd0, 1'b0);
    run_scn(1, 20);
    run_scn(2, 40);
    run_scn(3, 40);
    run_scn(4, 20);
    run_scn(5, 40);
    run_scn(6, 30);
    #2;
    reset = 1'b1;
    #1;
    check_eq("scn6_midhold_reset", outs(), 8'h00);
    run_scn(7, 50);
    run_scn(8, 25);
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
